// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: HD44780 write sequencer with power-up init and a single-request client port
module lcd_cmd_sequencer #(
  parameter int PWR_WAIT     = 40000,
  parameter int SETUP_CYCLES = 2,
  parameter int EN_CYCLES    = 12,
  parameter int CMD_WAIT     = 2000,
  parameter int CLR_WAIT     = 80000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       rs_in,
  input  logic [7:0] data_in,
  output logic       ready,
  output logic       init_done,
  output logic [7:0] lcd_data,
  output logic       lcd_en,
  output logic       lcd_rw,
  output logic       lcd_rs,
  output logic       lcd_blon
);
  localparam int M1 = PWR_WAIT > CLR_WAIT ? PWR_WAIT : CLR_WAIT;
  localparam int M2 = CMD_WAIT > SETUP_CYCLES ? CMD_WAIT : SETUP_CYCLES;
  localparam int M3 = M2 > EN_CYCLES ? M2 : EN_CYCLES;
  localparam int CW = $clog2((M1 > M3 ? M1 : M3) + 1);
  typedef enum logic [2:0] {PWRUP, LOAD, SETUP, PULSE, HOLD, WAIT, IDLE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, wait_last;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d, rom;
  logic          en_q, en_d, rs_q, rs_d, ready_q, ready_d, done_q, done_d, clr;
  always_comb begin
    rom = idx_q == 2'd0 ? 8'h38 : idx_q == 2'd1 ? 8'h0C : idx_q == 2'd2 ? 8'h01 : 8'h06;
    clr = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);
    wait_last = clr ? CW'(CLR_WAIT - 1) : CW'(CMD_WAIT - 1);
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    data_d  = data_q;
    rs_d    = rs_q;
    en_d    = en_q;
    ready_d = ready_q;
    done_d  = done_q;
    case (state_q)
      PWRUP: if (cnt_q == CW'(PWR_WAIT - 1)) begin
        state_d = LOAD;
        cnt_d   = '0;
        idx_d   = 2'd0;
      end
      LOAD: begin
        state_d = SETUP;
        cnt_d   = '0;
        data_d  = rom;
        rs_d    = 1'b0;
      end
      SETUP: if (cnt_q == CW'(SETUP_CYCLES)) begin
        state_d = PULSE;
        cnt_d   = '0;
        en_d    = 1'b1;
      end
      PULSE: if (cnt_q == CW'(EN_CYCLES - 1)) begin
        state_d = HOLD;
        cnt_d   = '0;
        en_d    = 1'b0;
      end
      HOLD: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: if (cnt_q == wait_last) begin
        cnt_d = '0;
        if (!done_q && idx_q != 2'd3) begin
          state_d = LOAD;
          idx_d   = idx_q + 2'd1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
          ready_d = 1'b1;
        end
      end
      IDLE: begin
        cnt_d = cnt_q;
        if (req && ready_q) begin
          state_d = SETUP;
          cnt_d   = '0;
          rs_d    = rs_in;
          data_d  = data_in;
          ready_d = 1'b0;
        end
      end
      default: state_d = PWRUP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= PWRUP;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end
  assign ready     = ready_q;
  assign init_done = done_q;
  assign lcd_data  = data_q;
  assign lcd_en    = en_q;
  assign lcd_rs    = rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_blon  = 1'b1;
endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb_lcd_cmd_sequencer: random client traffic checked against a pulse/ready schedule model
module tb_lcd_cmd_sequencer;
  localparam int PW = 10, SC = 2, EC = 4, CMW = 5, CLW = 20;
  localparam int NEVER = 1 << 30;
  logic clk = 1'b0, rst = 1'b0, req = 1'b0, rs_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic ready, init_done, lcd_en, lcd_rw, lcd_rs, lcd_blon;
  logic [7:0] lcd_data;
  lcd_cmd_sequencer #(.PWR_WAIT(PW), .SETUP_CYCLES(SC), .EN_CYCLES(EC), .CMD_WAIT(CMW), .CLR_WAIT(CLW)) dut (
    .clk(clk), .rst(rst), .req(req), .rs_in(rs_in), .data_in(data_in), .ready(ready),
    .init_done(init_done), .lcd_data(lcd_data), .lcd_en(lcd_en), .lcd_rw(lcd_rw),
    .lcd_rs(lcd_rs), .lcd_blon(lcd_blon));
  always #5 clk = ~clk;
  typedef struct {logic [7:0] d; logic rs; int t;} pulse_t;
  pulse_t exp_q[$];
  logic [7:0] init_rom [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
  int tests = 0, fails = 0, c = 0, ready_at = NEVER, done_at = NEVER, rise_c = 0;
  logic prev_en = 1'b0, rise_rs = 1'b0;
  logic [7:0] rise_d = 8'h00;
  function automatic int wait_of(logic rs, logic [7:0] d);
    return (!rs && d >= 8'h01 && d <= 8'h03) ? CLW : CMW;
  endfunction
  task automatic chk(string tag, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, c);
    end
  endtask
  task automatic step();
    pulse_t p;
    logic acc;
    acc = req && rst && c >= ready_at;
    @(posedge clk);
    #1;
    c++;
    if (!rst) begin
      chk("rst_en", 32'(lcd_en), 0);
      chk("rst_ready", 32'(ready), 0);
      chk("rst_done", 32'(init_done), 0);
      chk("rst_data", 32'(lcd_data), 0);
      chk("rst_rs", 32'(lcd_rs), 0);
      chk("rst_blon", 32'(lcd_blon), 1);
      exp_q.delete();
      ready_at = NEVER;
      done_at = NEVER;
      prev_en = 1'b0;
      return;
    end
    if (acc) begin
      p.d = data_in; p.rs = rs_in; p.t = c + SC + 1;
      exp_q.push_back(p);
      ready_at = c + SC + EC + 1 + wait_of(rs_in, data_in) + 1;
    end
    chk("ready", 32'(ready), 32'(c >= ready_at));
    chk("init_done", 32'(init_done), 32'(c >= done_at));
    chk("lcd_rw", 32'(lcd_rw), 0);
    chk("lcd_blon", 32'(lcd_blon), 1);
    if (lcd_en && !prev_en) begin
      if (exp_q.size() == 0) chk("extra_pulse", 1, 0);
      else begin
        p = exp_q.pop_front();
        chk("rise_time", c, p.t);
        chk("rise_data", 32'(lcd_data), 32'(p.d));
        chk("rise_rs", 32'(lcd_rs), 32'(p.rs));
      end
      rise_c = c; rise_d = lcd_data; rise_rs = lcd_rs;
    end
    if (lcd_en) begin
      chk("pulse_data_stable", 32'(lcd_data), 32'(rise_d));
      chk("pulse_rs_stable", 32'(lcd_rs), 32'(rise_rs));
    end
    if (!lcd_en && prev_en) begin
      chk("en_width", c - rise_c, EC);
      chk("hold_data", 32'(lcd_data), 32'(rise_d));
      chk("hold_rs", 32'(lcd_rs), 32'(rise_rs));
    end
    prev_en = lcd_en;
  endtask
  task automatic release_rst();
    pulse_t p;
    int t;
    rst = 1'b1;
    t = c + 1 + PW + SC + 1;
    for (int i = 0; i < 4; i++) begin
      p.d = init_rom[i]; p.rs = 1'b0; p.t = t;
      exp_q.push_back(p);
      if (i == 3) begin
        ready_at = t + EC + 1 + wait_of(1'b0, init_rom[i]);
        done_at = ready_at;
      end
      t += EC + 1 + wait_of(1'b0, init_rom[i]) + 1 + SC + 1;
    end
  endtask
  task automatic write(logic rs, logic [7:0] d);
    int n = 0;
    rs_in = rs; data_in = d; req = 1'b1;
    while (c < ready_at && n < 300) begin step(); n++; end
    chk("accept_timeout", 32'(c >= ready_at), 1);
    step();
    req = 1'b0;
  endtask
  initial begin
    int n;
    repeat (3) step();
    release_rst();
    repeat (150) step();
    write(1'b1, 8'h41);
    write(1'b0, 8'h02);
    write(1'b1, 8'h01);
    write(1'b0, 8'h03);
    for (int i = 0; i < 1500; i++) begin
      req = $urandom_range(0, 3) != 0;
      rs_in = 1'($urandom_range(0, 1));
      data_in = $urandom_range(0, 1) ? 8'($urandom_range(1, 3)) : 8'($urandom);
      step();
    end
    req = 1'b0;
    repeat (40) step();
    write(1'b0, 8'h38);
    n = 0;
    while (!lcd_en && n < 20) begin step(); n++; end
    chk("pulse_seen", 32'(lcd_en), 1);
    step();
    rst = 1'b0;
    repeat (3) step();
    release_rst();
    repeat (250) step();
    write(1'b1, 8'h55);
    repeat (40) step();
    chk("leftover_pulses", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lcd_cmd_sequencer.md
LCD_CMD_SEQUENCER -- requirements
Module: lcd_cmd_sequencer

Interface
REQ-001 SHALL have parameter PWR_WAIT, default 40000, power-on delay in clk cycles before the first init command.
REQ-002 SHALL have parameter SETUP_CYCLES, default 2, cycles with lcd_rs and lcd_data valid and lcd_en low before the enable pulse.
REQ-003 SHALL have parameter EN_CYCLES, default 12, width of the lcd_en high pulse in cycles.
REQ-004 SHALL have parameter CMD_WAIT, default 2000, post-pulse wait for ordinary commands and data writes.
REQ-005 SHALL have parameter CLR_WAIT, default 80000, post-pulse wait for clear (0x01) and home (0x02/0x03) commands.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-008 SHALL have port req, input, 1, write request from the client.
REQ-009 SHALL have port rs_in, input, 1, register select for the request: 0 = command, 1 = data.
REQ-010 SHALL have port data_in, input, 8, byte to write.
REQ-011 SHALL have port ready, output, 1, high when a request can be accepted.
REQ-012 SHALL have port init_done, output, 1, high once the init sequence has completed.
REQ-013 SHALL have port lcd_data, output, 8, HD44780 DB[7:0].
REQ-014 SHALL have port lcd_en, output, 1, HD44780 E strobe.
REQ-015 SHALL have port lcd_rw, output, 1, HD44780 R/W; tied to 0 (write only).
REQ-016 SHALL have port lcd_rs, output, 1, HD44780 RS.
REQ-017 SHALL have port lcd_blon, output, 1, backlight enable.

Function
REQ-018 SHALL implement states PWRUP, LOAD, SETUP, PULSE, HOLD, WAIT, IDLE.
REQ-019 In PWRUP, SHALL count PWR_WAIT cycles, then go to LOAD with init index 0.
REQ-020 SHALL use the fixed init sequence 0x38, 0x0C, 0x01, 0x06, all with rs=0.
REQ-021 In LOAD, SHALL drive lcd_data and lcd_rs from the init ROM at the current index, then enter SETUP.
REQ-022 In SETUP, SHALL hold lcd_en=0 for SETUP_CYCLES cycles, then enter PULSE.
REQ-023 In PULSE, SHALL hold lcd_en=1 for exactly EN_CYCLES cycles, then enter HOLD.
REQ-024 In HOLD, SHALL hold lcd_en=0 for 1 cycle with lcd_data and lcd_rs unchanged, then enter WAIT.
REQ-025 SHALL keep lcd_data and lcd_rs stable from the start of SETUP to the end of HOLD.
REQ-026 In WAIT, SHALL count CLR_WAIT cycles if the latched rs=0 and data is 0x01, 0x02 or 0x03; otherwise CMD_WAIT cycles.
REQ-027 On WAIT expiry during init with index < 3, SHALL increment the index and return to LOAD.
REQ-028 On WAIT expiry during init with index = 3, SHALL set init_done=1 and enter IDLE.
REQ-029 On WAIT expiry after init, SHALL enter IDLE.
REQ-030 SHALL assert ready only in IDLE with init_done=1, registered, with no combinational path from req.
REQ-031 On a cycle with req=1 and ready=1, SHALL latch rs_in and data_in into lcd_rs and lcd_data, deassert ready on the next cycle, and enter SETUP.
REQ-032 SHALL ignore req while ready=0; requests are neither queued nor acknowledged.
REQ-033 Latency SHALL be: first lcd_en rise = SETUP_CYCLES+1 cycles after the accept edge; ready returns SETUP_CYCLES+EN_CYCLES+1+WAIT+1 cycles after the accept edge.
REQ-034 Counters SHALL be wide enough for max(PWR_WAIT, CLR_WAIT) and SHALL not wrap; every count is terminal-compare and reloads on state entry.
REQ-035 init_done SHALL remain 1 until reset.
REQ-036 lcd_rw SHALL be 0 at all times.

Reset
REQ-037 While rst=0 at a clk edge, SHALL set state=PWRUP, counters=0, init index=0, lcd_en=0, lcd_rs=0, lcd_data=0x00, lcd_blon=1, ready=0, init_done=0.
REQ-038 Reset asserted mid-operation (including mid-pulse) SHALL force lcd_en=0 on the next edge and restart the full power-up and init sequence.
REQ-039 Reset SHALL have no asynchronous effect.

Verification (PWR_WAIT=10, SETUP_CYCLES=2, EN_CYCLES=4, CMD_WAIT=5, CLR_WAIT=20)
REQ-040 Release rst -> exactly 4 lcd_en pulses, each 4 cycles wide, with data 0x38, 0x0C, 0x01, 0x06; gap after 0x01 is 20 cycles; then init_done=1 and ready=1.
REQ-041 After init, req with rs_in=1, data_in=0x41 -> lcd_rs=1, lcd_data=0x41, lcd_en rises 3 cycles after accept and stays high 4 cycles; ready returns after CMD_WAIT.
REQ-042 req with rs_in=0, data_in=0x02 -> CLR_WAIT (20-cycle) gap; req with rs_in=1, data_in=0x01 -> CMD_WAIT (5-cycle) gap.
REQ-043 req held high continuously for 3 writes with data_in changing each cycle -> exactly one accept per ready window; no extra lcd_en pulses.
REQ-044 rst=0 during the PULSE of a user write -> lcd_en=0 on the next edge, ready=0, init_done=0; full init replays after release.
REQ-045 Any time -> lcd_rw=0, and lcd_data/lcd_rs never change while lcd_en=1.
